// File: rtl/hamming_pkg.sv
// Shared Hamming(12,8) definitions: widths, bit positions and the
// parity coverage helper used by both the encoder and the decoder.
package hamming_pkg;

  localparam int DATA_W = 8;
  localparam int CODE_W = 12;
  localparam int PAR_W  = 4;
  localparam int POS_W  = 4;
  localparam int CNT_W  = 4;

  // Index of the final serial bit of a codeword
  localparam logic [CNT_W-1:0] LAST_BIT = 4'd11;

  // 1-based codeword positions of D0..D7 (D0 in the lowest field)
  localparam logic [DATA_W*POS_W-1:0] DATA_POS =
    {4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3};

  // 1-based codeword positions of p1, p2, p4, p8 (p1 in the lowest field)
  localparam logic [PAR_W*POS_W-1:0] PAR_POS =
    {4'd8, 4'd4, 4'd2, 4'd1};

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Data bits covered by the parity bit sitting at position ppos: a data
  // bit is covered when its position shares the ppos bit.
  function automatic logic [DATA_W-1:0] data_mask(input logic [POS_W-1:0] ppos);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W; i++) begin
      m[i] = |(DATA_POS[i*POS_W +: POS_W] & ppos);
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_enc_core.sv
// Combinational Hamming(12,8) encoder: scatters the data byte into its
// codeword positions and fills the four even-parity positions.
module hamming_enc_core
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] code
);

  // Data bits land on the non-power-of-two positions
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
    localparam int POS = int'(DATA_POS[gi*POS_W +: POS_W]);
    assign code[POS-1] = data[gi];
  end

  // Each parity bit is the XOR of the data bits it covers (even parity)
  for (genvar gi = 0; gi < PAR_W; gi++) begin : g_par
    localparam logic [POS_W-1:0]  PPOS = PAR_POS[gi*POS_W +: POS_W];
    localparam logic [DATA_W-1:0] MASK = data_mask(PPOS);
    assign code[int'(PPOS)-1] = ^(data & MASK);
  end

endmodule

// File: rtl/hamming_enc_ser.sv
// Hamming(12,8) encoder with a serializer. An accepted byte is encoded,
// latched on code_out and shifted out one bit per cycle; a new byte may be
// accepted on the last bit so frames run back to back without gaps.
module hamming_enc_ser
  import hamming_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  output logic              ser_out,
  output logic              ser_frame
);

  ser_state_t         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [CODE_W-1:0]  shift_reg, shift_next;
  logic [CODE_W-1:0]  code_reg, code_next;
  logic               code_valid_reg, code_valid_next;
  logic [CODE_W-1:0]  enc_code;
  logic [CODE_W-1:0]  shift_adv;
  logic               accept;

  hamming_enc_core u_core (
    .data (in_data),
    .code (enc_code)
  );

  // Ready when idle or on the final bit; held low while in reset
  assign in_ready = rst_n & ((state_reg == IDLE) | (cnt_reg == LAST_BIT));
  assign accept   = in_valid & in_ready;

  // The outgoing bit always sits at the register end facing ser_out
  assign shift_adv = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);

  assign code_out   = code_reg;
  assign code_valid = code_valid_reg;
  assign ser_frame  = (state_reg == SHIFT);
  assign ser_out    = ser_frame & (LSB_FIRST ? shift_reg[0] : shift_reg[CODE_W-1]);

  // Next-state: load on accept, otherwise step through the frame
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    shift_next      = shift_reg;
    code_next       = code_reg;
    code_valid_next = accept;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          cnt_next   = '0;
          shift_next = enc_code;
          code_next  = enc_code;
        end
      end
      SHIFT: begin
        if (accept) begin
          // Only reachable on the last bit: chain straight into the new word
          cnt_next   = '0;
          shift_next = enc_code;
          code_next  = enc_code;
        end else if (cnt_reg == LAST_BIT) begin
          state_next = IDLE;
          cnt_next   = '0;
          shift_next = '0;
        end else begin
          cnt_next   = cnt_reg + 1'b1;
          shift_next = shift_adv;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        shift_next = '0;
      end
    endcase
  end

  // State register; reset aborts any frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      code_reg       <= '0;
      code_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      shift_reg      <= shift_next;
      code_reg       <= code_next;
      code_valid_reg <= code_valid_next;
    end
  end

endmodule

// File: tb/tb_hamming_enc_ser.sv
// Self-checking bench for hamming_enc_ser. The reference model encodes from
// the position/parity rules and tracks expected serial bits in a queue.
module tb_hamming_enc_ser;

  localparam bit LSB_FIRST = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [11:0] code_out;
  logic        code_valid;
  logic        ser_out;
  logic        ser_frame;

  int tests_run    = 0;
  int tests_failed = 0;

  bit          exp_q[$];
  logic [11:0] exp_code;
  logic        exp_cv;
  logic        accepted;
  logic [7:0]  last_byte;

  always #5 clk = ~clk;

  hamming_enc_ser #(.LSB_FIRST(LSB_FIRST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .code_out   (code_out),
    .code_valid (code_valid),
    .ser_out    (ser_out),
    .ser_frame  (ser_frame)
  );

  // Position p (1..12) holds data when p is not a power of two; parity
  // at p = 1,2,4,8 is the XOR of every other position sharing bit p.
  function automatic logic [11:0] ref_encode(input logic [7:0] d);
    logic [11:0] c;
    int di;
    bit par;
    c  = '0;
    di = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[di];
        di++;
      end
    end
    for (int p = 1; p <= 8; p = p * 2) begin
      par = 1'b0;
      for (int pos = 1; pos <= 12; pos++)
        if (pos != p && (pos & p) != 0) par ^= c[pos-1];
      c[p-1] = par;
    end
    return c;
  endfunction

  // Returns {syndrome, data}
  function automatic logic [11:0] ref_decode(input logic [11:0] c);
    logic [3:0] syn;
    logic [7:0] d;
    int di;
    syn = '0;
    d   = '0;
    di  = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if (c[pos-1]) syn ^= 4'(pos);
      if ((pos & (pos - 1)) != 0) begin
        d[di] = c[pos-1];
        di++;
      end
    end
    return {syn, d};
  endfunction

  function automatic bit ser_bit(input logic [11:0] c, input int k);
    return LSB_FIRST ? c[k] : c[11-k];
  endfunction

  function automatic logic [15:0] obs();
    return {ser_frame, ser_out, in_ready, code_valid, code_out};
  endfunction

  function automatic logic [15:0] exp_obs();
    logic f, s, r;
    f = (exp_q.size() > 0);
    s = f ? exp_q[0] : 1'b0;
    r = (exp_q.size() <= 1);
    return {f, s, r, exp_cv, exp_code};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_code = '0;
    exp_cv   = 1'b0;
    accepted = 1'b0;
  endtask

  // Drive one cycle of input, advance past the edge, update the model
  task automatic cycle(input logic v, input logic [7:0] d);
    logic        acc;
    logic [11:0] c;
    acc      = v && (exp_q.size() <= 1);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    exp_cv   = acc;
    accepted = acc;
    if (acc) begin
      c         = ref_encode(d);
      exp_code  = c;
      last_byte = d;
      for (int k = 0; k < 12; k++) exp_q.push_back(ser_bit(c, k));
      $display("[TB] word 0x%02h -> code 0x%03h", d, c);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (obs() !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h want %h", obs(), 16'h0000);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    tests_run++;
    if (obs() !== exp_obs()) begin
      tests_failed++;
      $display("FAIL reset_release: got %h want %h", obs(), exp_obs());
    end
  endtask

  task automatic test_zero();
    int frame_cnt;
    int ones;
    frame_cnt = 0;
    ones      = 0;
    cycle(1'b1, 8'h00);
    tests_run++;
    if (code_out !== 12'h000 || code_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_code: got %h/%b want 000/1", code_out, code_valid);
    end
    for (int k = 0; k < 13; k++) begin
      tests_run++;
      if (obs() !== exp_obs()) begin
        tests_failed++;
        $display("FAIL zero_cycle%0d: got %h want %h", k, obs(), exp_obs());
      end
      if (ser_frame) frame_cnt++;
      if (ser_out) ones++;
      cycle(1'b0, 8'h00);
    end
    tests_run++;
    if (frame_cnt != 12 || ones != 0) begin
      tests_failed++;
      $display("FAIL zero_frame: got len %0d ones %0d want len 12 ones 0", frame_cnt, ones);
    end
  endtask

  task automatic test_ff();
    logic [11:0] ff_code;
    ff_code = 12'hF77;
    cycle(1'b1, 8'hFF);
    tests_run++;
    if (code_out !== ff_code) begin
      tests_failed++;
      $display("FAIL ff_code: got %h want %h", code_out, ff_code);
    end
    for (int k = 0; k < 12; k++) begin
      tests_run++;
      if (ser_frame !== 1'b1 || ser_out !== ser_bit(ff_code, k)) begin
        tests_failed++;
        $display("FAIL ff_bit%0d: got frame %b bit %b want frame 1 bit %b",
                 k, ser_frame, ser_out, ser_bit(ff_code, k));
      end
      cycle(1'b0, 8'h00);
    end
    tests_run++;
    if (obs() !== exp_obs()) begin
      tests_failed++;
      $display("FAIL ff_end: got %h want %h", obs(), exp_obs());
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] want [2];
    int nv, run, rdy, first, last;
    bit second;
    want   = '{12'h007, 12'h888};
    nv     = 0;
    run    = 0;
    rdy    = 0;
    first  = -1;
    last   = -1;
    second = 1'b0;
    cycle(1'b1, 8'h01);
    for (int i = 0; i < 28; i++) begin
      tests_run++;
      if (obs() !== exp_obs()) begin
        tests_failed++;
        $display("FAIL b2b_cycle%0d: got %h want %h", i, obs(), exp_obs());
      end
      if (ser_frame) begin
        run++;
        if (in_ready) rdy++;
        if (first < 0) first = i;
        last = i;
      end
      if (code_valid && nv < 2) begin
        tests_run++;
        if (code_out !== want[nv]) begin
          tests_failed++;
          $display("FAIL b2b_word%0d: got %h want %h", nv, code_out, want[nv]);
        end
        nv++;
      end
      cycle(!second, 8'h80);
      if (accepted) second = 1'b1;
    end
    tests_run++;
    if (run != 24 || (last - first + 1) != 24 || rdy != 2 || nv != 2) begin
      tests_failed++;
      $display("FAIL b2b_frame: got run %0d span %0d ready %0d words %0d want 24 24 2 2",
               run, last - first + 1, rdy, nv);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 8'hFF);
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b0, 8'h00);
      tests_run++;
      if (obs() !== exp_obs()) begin
        tests_failed++;
        $display("FAIL rstmid_bit%0d: got %h want %h", k, obs(), exp_obs());
      end
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (obs() !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rstmid_async: got %h want %h", obs(), 16'h0000);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (obs() !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rstmid_held: got %h want %h", obs(), 16'h0000);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      cycle(1'b0, 8'h00);
      tests_run++;
      if (obs() !== exp_obs()) begin
        tests_failed++;
        $display("FAIL rstmid_after%0d: got %h want %h", k, obs(), exp_obs());
      end
    end
  endtask

  task automatic test_valid_pulse();
    logic [7:0] d;
    d = 8'($urandom);
    cycle(1'b1, d);
    for (int k = 1; k <= 14; k++) begin
      cycle((k >= 3 && k <= 6), 8'($urandom));
      tests_run++;
      if (obs() !== exp_obs()) begin
        tests_failed++;
        $display("FAIL pulse_cycle%0d: got %h want %h", k, obs(), exp_obs());
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] dec;
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 2) == 0), 8'($urandom));
      tests_run++;
      if (obs() !== exp_obs()) begin
        tests_failed++;
        $display("FAIL rand_cycle%0d: got %h want %h", i, obs(), exp_obs());
      end
      if (code_valid) begin
        dec = ref_decode(code_out);
        tests_run++;
        if (dec !== {4'h0, last_byte}) begin
          tests_failed++;
          $display("FAIL rand_decode%0d: got %h want %h", i, dec, {4'h0, last_byte});
        end
      end
    end
  endtask

  task automatic test_all_bytes();
    int idx;
    int budget;
    logic [11:0] dec;
    idx    = 0;
    budget = 256 * 13 + 40;
    while ((idx < 256 || exp_q.size() > 0) && budget > 0) begin
      budget--;
      cycle(idx < 256, 8'(idx));
      if (accepted) idx++;
      tests_run++;
      if (obs() !== exp_obs()) begin
        tests_failed++;
        $display("FAIL all_cycle idx%0d: got %h want %h", idx, obs(), exp_obs());
      end
      if (code_valid) begin
        dec = ref_decode(code_out);
        tests_run++;
        if (dec !== {4'h0, last_byte}) begin
          tests_failed++;
          $display("FAIL all_decode: got %h want %h", dec, {4'h0, last_byte});
        end
      end
    end
    tests_run++;
    if (idx != 256 || budget <= 0) begin
      tests_failed++;
      $display("FAIL all_done: got %0d words want 256 (budget %0d)", idx, budget);
    end
  endtask

  initial begin
    model_reset();
    last_byte = '0;
    test_reset();
    test_zero();
    test_ff();
    test_back_to_back();
    test_reset_mid();
    test_valid_pulse();
    test_random();
    test_all_bytes();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hamming_enc_ser.md
HAMMING_ENC_SER -- requirements
Module: hamming_enc_ser

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1; 1 = serialize code[0] first, 0 = code[11] first.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  in_data holds a word to encode.
REQ-005 SHALL have port in_ready  output  1  encoder can accept a word this cycle.
REQ-006 SHALL have port in_data  input  8  data byte D[7:0].
REQ-007 SHALL have port code_out  output  12  registered Hamming(12,8) codeword of the last accepted byte.
REQ-008 SHALL have port code_valid  output  1  one-cycle pulse when code_out updates.
REQ-009 SHALL have port ser_out  output  1  serial codeword bit.
REQ-010 SHALL have port ser_frame  output  1  high for exactly the 12 cycles ser_out carries a codeword.

Function
REQ-011 Codeword mapping SHALL be code[i] = position i+1; data D0..D7 at positions 3,5,6,7,9,10,11,12; parity at positions 1,2,4,8.
REQ-012 Parity SHALL be even: p1 = XOR(pos 3,5,7,9,11), p2 = XOR(3,6,7,10,11), p4 = XOR(5,6,7,12), p8 = XOR(9,10,11,12).
REQ-013 Accept SHALL occur on a rising edge where in_valid and in_ready are both 1; in_data is not sampled otherwise.
REQ-014 FSM states SHALL be IDLE and SHIFT; IDLE -> SHIFT on accept; SHIFT -> IDLE after bit 11 unless an accept occurs in that cycle, in which case SHIFT continues with the new word.
REQ-015 in_ready SHALL be 1 in IDLE and in SHIFT when the bit counter equals 11; 0 otherwise.
REQ-016 On accept, code_out, the shift register and counter (0) SHALL load on the same edge; code_valid SHALL be 1 in the following cycle only.
REQ-017 First serial bit SHALL appear on ser_out in the cycle immediately after the accept edge (latency 1); bits follow one per cycle with no gaps.
REQ-018 Back-to-back accepts SHALL produce contiguous frames: ser_frame stays high for 24 consecutive cycles for two words with no idle cycle.
REQ-019 ser_out SHALL be 0 whenever ser_frame is 0.
REQ-020 code_out SHALL hold its value until the next accept.
REQ-021 in_valid deasserting during SHIFT SHALL have no effect on the frame in progress.

Reset
REQ-022 rst_n low SHALL immediately force: state IDLE, counter 0, shift register 0, code_out 0x000, code_valid 0, ser_out 0, ser_frame 0, in_ready 1 (after release).
REQ-023 Reset asserted mid-frame SHALL abort the frame; no remaining bits are emitted after release.
REQ-024 in_ready SHALL be 0 while rst_n is low.

Structure
REQ-025 DATA_W=8, CODE_W=12 and the parity position constants SHALL live in shared package hamming_pkg, reused by the decoder.
REQ-026 Parity generation SHALL be a purely combinational sub-module hamming_enc_core (8 in, 12 out); all sequencing stays in hamming_enc_ser.

Verification
REQ-027 Accept 0x00 -> code_out 0x000, code_valid pulse, ser_frame high 12 cycles, ser_out all 0.
REQ-028 Accept 0xFF -> code_out 0xF77; LSB_FIRST=1 ser_out sequence 1,1,1,0,1,1,1,0,1,1,1,1.
REQ-029 Accept 0x01 then 0x80 back-to-back (in_valid held) -> code_out 0x007 then 0x888; ser_frame high 24 contiguous cycles; in_ready high only on counter 11.
REQ-030 rst_n low at bit 5 of 0xFF frame -> ser_frame and ser_out 0 immediately, code_out 0x000; after release, in_ready 1 and no residual bits.
REQ-031 in_valid pulsed during SHIFT (counter != 11) -> ignored; frame bits unchanged, code_out unchanged.
REQ-032 All 256 inputs via hamming_enc_core -> feeding code_out to the decoder returns the original byte with zero syndrome.
